// File: rtl/regfile_mp.sv
// regfile_mp: multi-ported register file with a per-register busy scoreboard.
//
// After reset the file sweeps every entry to zero (state CLEAR), one entry per
// cycle, and then enters RUN. In RUN it accepts two write ports and one
// reserve port. Reads are combinational on NUM_RD independent ports.
//
// Parameters:
//   REG_SIZE  data width per register
//   NUM_REGS  register count (power of two, >= 4); A = $clog2(NUM_REGS)
//   NUM_RD    number of read ports (1..4)
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   Ready               1 once the clear sweep is done (state RUN)
//   RdAddr / RdData     packed read address/data, port i at slice i
//   RdBusy              busy bit of the register addressed on each read port
//   WE0/WA0/WD0         write port 0
//   WE1/WA1/WD1         write port 1 (wins over port 0 on the same address)
//   Reserve/ReserveReg  set the busy bit of ReserveReg (wins over a write)
//
// Optional feature macro: REGFILE_BYPASS_EN
//   When defined, a read that matches a same-cycle write returns the write
//   data (WD1 over WD0) and reports busy only if a same-cycle Reserve matches.
//   When undefined, reads return the stored value and busy bit.
//
// Register 0 is hardwired to zero and can never be marked busy.

module regfile_mp #(
    parameter int REG_SIZE = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 3,
    localparam int A       = $clog2(NUM_REGS)
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       Ready,
    input  logic [NUM_RD*A-1:0]        RdAddr,
    output logic [NUM_RD*REG_SIZE-1:0] RdData,
    output logic [NUM_RD-1:0]          RdBusy,
    input  logic                       WE0,
    input  logic [A-1:0]               WA0,
    input  logic [REG_SIZE-1:0]        WD0,
    input  logic                       WE1,
    input  logic [A-1:0]               WA1,
    input  logic [REG_SIZE-1:0]        WD1,
    input  logic                       Reserve,
    input  logic [A-1:0]               ReserveReg
);

    // Parameter sanity, checked at elaboration.
    if (NUM_REGS < 4 || (NUM_REGS & (NUM_REGS - 1)) != 0) begin : g_bad_num_regs
        $error("regfile_mp: NUM_REGS must be a power of two and >= 4");
    end
    if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
        $error("regfile_mp: NUM_RD must be in 1..4");
    end

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t              state_reg, state_next;
    logic [A-1:0]        clr_cnt_reg, clr_cnt_next;
    logic [REG_SIZE-1:0] mem [NUM_REGS];
    logic [NUM_REGS-1:0] busy_reg;

    logic run;
    logic wr_ok;
    logic we0_ok;
    logic we1_ok;
    logic rsv_ok;

    assign run   = (state_reg == RUN);
    assign Ready = run;

    // Updates only take effect in RUN and not on an edge that resets the file.
    // Address 0 is filtered here so nothing downstream has to care.
    // Port 0 is dropped when port 1 targets the same address.
    assign wr_ok  = run && !rst;
    assign we1_ok = wr_ok && WE1 && (WA1 != '0);
    assign we0_ok = wr_ok && WE0 && (WA0 != '0) && !(WE1 && (WA1 == WA0));
    assign rsv_ok = wr_ok && Reserve && (ReserveReg != '0);

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= CLEAR;
            clr_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            clr_cnt_reg <= clr_cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        clr_cnt_next = clr_cnt_reg;
        case (state_reg)
            CLEAR: begin
                clr_cnt_next = clr_cnt_reg + 1'b1;
                if (clr_cnt_reg == A'(NUM_REGS - 1)) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                state_next = RUN;
            end
            default: begin
                state_next = CLEAR;
            end
        endcase
    end

    // ---------------- storage ----------------
    // The sweep zeroes entry clr_cnt each CLEAR cycle; contents are not reset
    // directly, reads are masked until the sweep completes instead.
    always_ff @(posedge clk) begin
        if (!run) begin
            mem[clr_cnt_reg] <= '0;
        end else begin
            if (we0_ok) begin
                mem[WA0] <= WD0;
            end
            if (we1_ok) begin
                mem[WA1] <= WD1;
            end
        end
    end

    // Busy scoreboard: Reserve has priority over a write clearing the bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_reg <= '0;
        end else if (run) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (rsv_ok && (ReserveReg == A'(i))) begin
                    busy_reg[i] <= 1'b1;
                end else if ((we0_ok && (WA0 == A'(i))) || (we1_ok && (WA1 == A'(i)))) begin
                    busy_reg[i] <= 1'b0;
                end
            end
        end
    end

    // ---------------- read ports ----------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [A-1:0]        ra;
            logic [REG_SIZE-1:0] rd_raw;
            logic                busy_raw;

            assign ra = RdAddr[gi*A +: A];

`ifdef REGFILE_BYPASS_EN
            always_comb begin
                rd_raw   = mem[ra];
                busy_raw = busy_reg[ra];
                if (we1_ok && (WA1 == ra)) begin
                    rd_raw   = WD1;
                    busy_raw = rsv_ok && (ReserveReg == ra);
                end else if (we0_ok && (WA0 == ra)) begin
                    rd_raw   = WD0;
                    busy_raw = rsv_ok && (ReserveReg == ra);
                end
            end
`else
            assign rd_raw   = mem[ra];
            assign busy_raw = busy_reg[ra];
`endif

            // Zero during CLEAR (unswept entries may hold X) and for register 0.
            assign RdData[gi*REG_SIZE +: REG_SIZE] = (run && (ra != '0)) ? rd_raw : '0;
            assign RdBusy[gi] = run && (ra != '0) && busy_raw;
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp (REG_SIZE=32, NUM_REGS=32, NUM_RD=3).
// Expected values are pushed into a scoreboard queue as stimulus is applied
// and popped when the corresponding DUT output is sampled.
module tb_regfile_mp;

    localparam int W  = 32;
    localparam int NR = 32;
    localparam int ND = 3;
    localparam int A  = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            ready;
    logic [ND*A-1:0] rd_addr;
    logic [ND*W-1:0] rd_data;
    logic [ND-1:0]   rd_busy;
    logic            we0, we1, reserve;
    logic [A-1:0]    wa0, wa1, reserve_reg;
    logic [W-1:0]    wd0, wd1;

    always #5 clk = ~clk;

    regfile_mp #(.REG_SIZE(W), .NUM_REGS(NR), .NUM_RD(ND)) dut (
        .clk        (clk),
        .rst        (rst),
        .Ready      (ready),
        .RdAddr     (rd_addr),
        .RdData     (rd_data),
        .RdBusy     (rd_busy),
        .WE0        (we0),
        .WA0        (wa0),
        .WD0        (wd0),
        .WE1        (we1),
        .WA1        (wa1),
        .WD1        (wd1),
        .Reserve    (reserve),
        .ReserveReg (reserve_reg)
    );

    typedef struct {
        string       tag;
        logic [95:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void exp_push(input string tag, input logic [95:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endfunction

    task automatic check_obs(input logic [95:0] obs);
        exp_t e;
        e = sb.pop_front();
        checks++;
        assert (obs === e.val) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", e.tag, obs, e.val);
        end
        $display("check %s: observed=%0h expected=%0h", e.tag, obs, e.val);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int p, input logic [A-1:0] a);
        rd_addr[p*A +: A] = a;
    endtask

    function automatic logic [95:0] port_data(input int p);
        return {64'd0, rd_data[p*W +: W]};
    endfunction

    task automatic idle();
        we0 = 1'b0; we1 = 1'b0; reserve = 1'b0;
        wa0 = '0; wa1 = '0; reserve_reg = '0;
        wd0 = '0; wd1 = '0;
    endtask

    // Counts edges after rst release: Ready must rise after exactly NR edges,
    // reads must stay zero before that. Writes/reserves mid-sweep must be ignored.
    task automatic sweep_check(input string tag);
        for (int i = 1; i <= NR + 1; i++) begin
            if (i == 5) begin
                we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hAAAA_5555;
                reserve = 1'b1; reserve_reg = 5'd4;
            end else if (i == 6) begin
                idle();
            end
            tick();
            exp_push($sformatf("%s_ready_%0d", tag, i), {95'd0, (i >= NR)});
            check_obs({95'd0, ready});
            if (i < NR) begin
                exp_push($sformatf("%s_rddata_%0d", tag, i), '0);
                check_obs({{(96-ND*W){1'b0}}, rd_data});
                exp_push($sformatf("%s_rdbusy_%0d", tag, i), '0);
                check_obs({{(96-ND){1'b0}}, rd_busy});
            end
        end
    endtask

    initial begin
        logic [W-1:0] same_cycle;
        idle();
        rd_addr = '0;
        rst = 1'b1;
        tick();
        tick();
        exp_push("reset_ready", 96'd0);
        check_obs({95'd0, ready});
        exp_push("reset_busy", 96'd0);
        check_obs({{(96-ND){1'b0}}, rd_busy});

        // Initial sweep, reading regs 3, 4, 9.
        set_rd(0, 5'd3); set_rd(1, 5'd4); set_rd(2, 5'd9);
        rst = 1'b0;
        exp_push("release_ready", 96'd0);
        check_obs({95'd0, ready});
        sweep_check("sweep1");

        // Mid-sweep write to 3 / reserve of 4 must have been dropped.
        exp_push("ignored_wr_r3", 96'd0);
        check_obs(port_data(0));
        exp_push("ignored_rsv_r4", 96'd0);
        check_obs({95'd0, rd_busy[1]});

        // Write reg 5; same-cycle read shows old value unless bypassing.
        we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEAD_BEEF;
        set_rd(0, 5'd5);
        #1;
`ifdef REGFILE_BYPASS_EN
        same_cycle = 32'hDEAD_BEEF;
`else
        same_cycle = 32'h0;
`endif
        exp_push("wr5_same_cycle", {64'd0, same_cycle});
        check_obs(port_data(0));
        tick();
        idle();
        #1;
        exp_push("wr5_next_cycle", {64'd0, 32'hDEAD_BEEF});
        check_obs(port_data(0));

        // Both ports to reg 7: port 1 wins.
        we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h11;
        we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h22;
        tick();
        idle();
        set_rd(1, 5'd7);
        #1;
        exp_push("wr7_port1_wins", {64'd0, 32'h22});
        check_obs(port_data(1));

        // Two different addresses in one cycle both commit.
        we0 = 1'b1; wa0 = 5'd10; wd0 = 32'h1234;
        we1 = 1'b1; wa1 = 5'd11; wd1 = 32'h5678;
        tick();
        idle();
        set_rd(0, 5'd10); set_rd(1, 5'd11);
        #1;
        exp_push("wr10", {64'd0, 32'h1234});
        check_obs(port_data(0));
        exp_push("wr11", {64'd0, 32'h5678});
        check_obs(port_data(1));

        // Register 0: write and reserve ignored on all ports.
        we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFF_FFFF;
        we1 = 1'b1; wa1 = 5'd0; wd1 = 32'hFFFF_FFFF;
        reserve = 1'b1; reserve_reg = 5'd0;
        tick();
        idle();
        set_rd(0, 5'd0); set_rd(1, 5'd0); set_rd(2, 5'd0);
        #1;
        exp_push("r0_data_all", 96'd0);
        check_obs({{(96-ND*W){1'b0}}, rd_data});
        exp_push("r0_busy_all", 96'd0);
        check_obs({{(96-ND){1'b0}}, rd_busy});

        // Scoreboard on reg 9.
        set_rd(2, 5'd9);
        reserve = 1'b1; reserve_reg = 5'd9;
        tick();
        idle();
        exp_push("rsv9_busy", 96'd1);
        check_obs({95'd0, rd_busy[2]});
        we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h5;
        tick();
        idle();
        exp_push("wr9_busy_clear", 96'd0);
        check_obs({95'd0, rd_busy[2]});
        exp_push("wr9_data", {64'd0, 32'h5});
        check_obs(port_data(2));
        we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h5;
        reserve = 1'b1; reserve_reg = 5'd9;
        tick();
        idle();
        exp_push("wr_rsv9_data", {64'd0, 32'h5});
        check_obs(port_data(2));
        exp_push("wr_rsv9_busy", 96'd1);
        check_obs({95'd0, rd_busy[2]});

        // Reset in RUN, then again at sweep cycle 10.
        set_rd(0, 5'd5); set_rd(1, 5'd4); set_rd(2, 5'd9);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        exp_push("mid_sweep_ready", 96'd0);
        check_obs({95'd0, ready});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sweep_check("sweep2");

        // Reset cleared the busy bit; sweep zeroed data.
        exp_push("post_reset_busy9", 96'd0);
        check_obs({95'd0, rd_busy[2]});
        exp_push("post_reset_data9", 96'd0);
        check_obs(port_data(2));
        exp_push("post_reset_data5", 96'd0);
        check_obs(port_data(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
